cpu_run_controller: RTL and testbench

Synthesizable run controller for the MIPS harvard CPU in test and FPGA harness configurations. It sequences CPU reset and clock enable, and checks that `active` rises after reset. It then counts execution cycles, enforces a parametrised timeout and an optional halt-on-zero-PC mode, and captures NUM_REGS monitored register values when the CPU stops.

---
 rtl/cpu_harness_pkg.sv | 55 +++++
 rtl/sat_counter.sv | 24 ++
 rtl/cpu_run_controller.sv | 109 ++++++++++
 tb/tb_cpu_run_controller.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_harness_pkg.sv
// Shared types for the CPU run harness: controller states, output bundle and
// register channel indices.
package cpu_harness_pkg;

  localparam int REG_W = 32;

  // Register channel indices within cpu_regs/result_regs
  localparam int CH_V0 = 0;
  localparam int CH_V3 = 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET_CPU = 3'd1,
    ST_CHECK     = 3'd2,
    ST_RUN       = 3'd3,
    ST_DONE      = 3'd4,
    ST_TIMEOUT   = 3'd5,
    ST_FAULT     = 3'd6
  } run_state_t;

  typedef struct packed {
    logic cpu_reset;
    logic cpu_clk_enable;
    logic busy;
    logic done;
    logic timed_out;
    logic reset_fault;
  } run_outputs_t;

  // Moore output decode; the caller registers the result of the next state
  function automatic run_outputs_t decode_outputs(input run_state_t s);
    run_outputs_t o;
    o = '0;
    case (s)
      ST_RESET_CPU: begin
        o.cpu_reset = 1'b1;
        o.busy      = 1'b1;
      end
      ST_CHECK, ST_RUN: begin
        o.cpu_clk_enable = 1'b1;
        o.busy           = 1'b1;
      end
      ST_DONE:    o.done        = 1'b1;
      ST_TIMEOUT: o.timed_out   = 1'b1;
      ST_FAULT:   o.reset_fault = 1'b1;
      default:    o = '0;
    endcase
    return o;
  endfunction

  function automatic logic start_allowed(input run_state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_TIMEOUT) || (s == ST_FAULT);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset, synchronous clear
// and count enable. Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_run_controller.sv
// Run controller for the MIPS harvard CPU harness: sequences CPU reset and
// clock enable, checks active after reset, times the run and captures registers.
module cpu_run_controller
  import cpu_harness_pkg::*;
#(
  parameter int RESET_CYCLES    = 1,
  parameter int TIMEOUT_CYCLES  = 15,
  parameter int NUM_REGS        = 2,
  parameter int CNT_W           = 32,
  parameter int HALT_ON_ZERO_PC = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      cpu_active,
  input  logic [REG_W-1:0]          cpu_instr_address,
  input  logic [REG_W*NUM_REGS-1:0] cpu_regs,
  output logic                      cpu_reset,
  output logic                      cpu_clk_enable,
  output logic                      busy,
  output logic                      done,
  output logic                      timed_out,
  output logic                      reset_fault,
  output logic [CNT_W-1:0]          cycle_count,
  output logic [REG_W*NUM_REGS-1:0] result_regs
);

  localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LAST     = RST_W'(RESET_CYCLES - 1);
  // The RUN cycle whose edge would bring the count up to TIMEOUT_CYCLES
  localparam logic [CNT_W:0]   TIMEOUT_LAST = (CNT_W + 1)'(TIMEOUT_CYCLES - 1);

  run_state_t       state;
  run_state_t       next_state;
  logic [RST_W-1:0] rst_cnt;
  logic [RST_W-1:0] rst_cnt_next;
  run_outputs_t     outs;
  logic             start_accept;
  logic             stop;
  logic             run_exit;

  always_comb begin
    // NOTE: every signal gets a default first so no latch is inferred on unlisted paths.
    next_state   = state;
    rst_cnt_next = rst_cnt;
    start_accept = 1'b0;
    stop         = !cpu_active || ((HALT_ON_ZERO_PC != 0) && (cpu_instr_address == '0));

    if (start_allowed(state) && start) begin
      next_state   = ST_RESET_CPU;
      rst_cnt_next = '0;
      start_accept = 1'b1;
    end else begin
      case (state)
        ST_RESET_CPU: begin
          if (rst_cnt == RST_LAST) next_state = ST_CHECK;
          else                     rst_cnt_next = rst_cnt + 1'b1;
        end
        ST_CHECK: next_state = cpu_active ? ST_RUN : ST_FAULT;
        ST_RUN: begin
          // Stop wins over timeout when both land on the same cycle
          if (stop)                                         next_state = ST_DONE;
          else if ({1'b0, cycle_count} >= TIMEOUT_LAST)     next_state = ST_TIMEOUT;
        end
        ST_IDLE, ST_DONE, ST_TIMEOUT, ST_FAULT: next_state = state;
        default: next_state = ST_IDLE;
      endcase
    end
  end

  assign run_exit = (state == ST_RUN) && (next_state != ST_RUN);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      rst_cnt     <= '0;
      outs        <= '0;
      // NOTE: capture registers are reset too, so the outputs are all zero in IDLE after reset.
      result_regs <= '0;
    end else begin
      state   <= next_state;
      rst_cnt <= rst_cnt_next;
      outs    <= decode_outputs(next_state);
      if (start_accept) begin
        result_regs <= '0;
      end else if (run_exit) begin
        result_regs <= cpu_regs;
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cycle_counter (
    .clk    (clk),
    .rst_n  (reset),
    .clear  (start_accept),
    .enable (state == ST_RUN),
    .count  (cycle_count)
  );

  assign cpu_reset      = outs.cpu_reset;
  assign cpu_clk_enable = outs.cpu_clk_enable;
  assign busy           = outs.busy;
  assign done           = outs.done;
  assign timed_out      = outs.timed_out;
  assign reset_fault    = outs.reset_fault;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: nominal, timeout, fault, halt-on-zero-PC,
// simultaneous stop/timeout, long CPU reset and mid-run controller reset.
module tb_cpu_run_controller;
  import cpu_harness_pkg::*;

  localparam logic [5:0] O_IDLE   = 6'b000000;
  localparam logic [5:0] O_RESET  = 6'b101000;
  localparam logic [5:0] O_ACTIVE = 6'b011000;
  localparam logic [5:0] O_DONE   = 6'b000100;
  localparam logic [5:0] O_TOUT   = 6'b000010;
  localparam logic [5:0] O_FAULT  = 6'b000001;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        start_r3;
  logic        active;
  logic        active_r3;
  logic [31:0] pc;
  logic [63:0] regs;

  logic        a_rst, a_en, a_busy, a_done, a_tout, a_fault;
  logic [31:0] a_count;
  logic [63:0] a_result;
  logic        h_rst, h_en, h_busy, h_done, h_tout, h_fault;
  logic [31:0] h_count;
  logic [63:0] h_result;
  logic        r_rst, r_en, r_busy, r_done, r_tout, r_fault;
  logic [31:0] r_count;
  logic [63:0] r_result;

  wire [5:0] a_st = {a_rst, a_en, a_busy, a_done, a_tout, a_fault};
  wire [5:0] h_st = {h_rst, h_en, h_busy, h_done, h_tout, h_fault};
  wire [5:0] r_st = {r_rst, r_en, r_busy, r_done, r_tout, r_fault};

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  cpu_run_controller #(
    .RESET_CYCLES(1), .TIMEOUT_CYCLES(15), .NUM_REGS(2), .CNT_W(32), .HALT_ON_ZERO_PC(0)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cpu_active(active),
    .cpu_instr_address(pc), .cpu_regs(regs),
    .cpu_reset(a_rst), .cpu_clk_enable(a_en), .busy(a_busy), .done(a_done),
    .timed_out(a_tout), .reset_fault(a_fault), .cycle_count(a_count), .result_regs(a_result)
  );

  cpu_run_controller #(
    .RESET_CYCLES(1), .TIMEOUT_CYCLES(15), .NUM_REGS(2), .CNT_W(32), .HALT_ON_ZERO_PC(1)
  ) dut_h (
    .clk(clk), .reset(reset), .start(start), .cpu_active(active),
    .cpu_instr_address(pc), .cpu_regs(regs),
    .cpu_reset(h_rst), .cpu_clk_enable(h_en), .busy(h_busy), .done(h_done),
    .timed_out(h_tout), .reset_fault(h_fault), .cycle_count(h_count), .result_regs(h_result)
  );

  cpu_run_controller #(
    .RESET_CYCLES(3), .TIMEOUT_CYCLES(15), .NUM_REGS(2), .CNT_W(32), .HALT_ON_ZERO_PC(0)
  ) dut_r3 (
    .clk(clk), .reset(reset), .start(start_r3), .cpu_active(active_r3),
    .cpu_instr_address(pc), .cpu_regs(regs),
    .cpu_reset(r_rst), .cpu_clk_enable(r_en), .busy(r_busy), .done(r_done),
    .timed_out(r_tout), .reset_fault(r_fault), .cycle_count(r_count), .result_regs(r_result)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_compared++;
    assert (observed === expected)
    else begin
      n_mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a run with active high, stop it by dropping active during RUN cycle n.
  task automatic run_to_done(input string tag, input int n, input logic [31:0] v0);
    regs  = 64'h0000_1111_0000_2222;
    start = 1'b1;
    tick();
    start  = 1'b0;
    active = 1'b1;
    pc     = 32'h0000_0100;
    check({tag, "_reset_st"}, a_st, O_RESET);
    check({tag, "_reset_cnt"}, a_count, 0);
    check({tag, "_reset_res"}, a_result, 0);
    tick();
    check({tag, "_check_st"}, a_st, O_ACTIVE);
    tick();
    for (int k = 1; k < n; k++) tick();
    check({tag, "_run_cnt"}, a_count, 64'(n - 1));
    check({tag, "_run_st"}, a_st, O_ACTIVE);
    active = 1'b0;
    regs   = {32'h0000_BEEF, v0};
    tick();
    check({tag, "_done_st"}, a_st, O_DONE);
    check({tag, "_done_cnt"}, a_count, 64'(n));
    check({tag, "_done_v0"}, {32'h0, a_result[CH_V0*32 +: 32]}, {32'h0, v0});
    check({tag, "_done_v3"}, {32'h0, a_result[CH_V3*32 +: 32]}, 64'h0000_BEEF);
    check({tag, "_h_done_st"}, h_st, O_DONE);
    check({tag, "_h_done_cnt"}, h_count, 64'(n));
    regs = 64'h0;
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    start_r3  = 1'b0;
    active    = 1'b0;
    active_r3 = 1'b0;
    pc        = 32'h0000_0100;
    regs      = 64'h0;
    repeat (2) tick();
    check("rst_st", a_st, O_IDLE);
    check("rst_cnt", a_count, 0);
    check("rst_res", a_result, 0);
    check("rst_h_st", h_st, O_IDLE);
    check("rst_r3_st", r_st, O_IDLE);
    reset = 1'b1;
    tick();
    check("idle_hold_st", a_st, O_IDLE);

    // RESET_CYCLES = 3: cpu_reset high for exactly three cycles, then CHECK and RUN
    start_r3 = 1'b1;
    tick();
    start_r3  = 1'b0;
    active_r3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("r3_reset_cyc%0d", i), r_st, O_RESET);
      tick();
    end
    check("r3_check_st", r_st, O_ACTIVE);
    tick();
    check("r3_run_st", r_st, O_ACTIVE);
    check("r3_run_cnt", r_count, 0);
    regs      = 64'h0000_0005_0000_0007;
    active_r3 = 1'b0;
    tick();
    check("r3_done_st", r_st, O_DONE);
    check("r3_done_cnt", r_count, 1);
    check("r3_done_res", r_result, 64'h0000_0005_0000_0007);
    regs = 64'h0;

    // Nominal run: active drops in RUN cycle 5, v0 = 0x2A
    run_to_done("nom", 5, 32'h0000_002A);
    check("nom_tout", {63'h0, a_tout}, 0);

    // Timeout with a start pulse ignored mid-run
    start = 1'b1;
    tick();
    start  = 1'b0;
    active = 1'b1;
    regs   = 64'h1234_5678_9ABC_DEF0;
    check("to_clear_cnt", a_count, 0);
    tick();
    tick();
    repeat (4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("to_ignore_start_st", a_st, O_ACTIVE);
    check("to_ignore_start_cnt", a_count, 5);
    repeat (9) tick();
    check("to_pre_st", a_st, O_ACTIVE);
    check("to_pre_cnt", a_count, 14);
    tick();
    check("to_st", a_st, O_TOUT);
    check("to_cnt", a_count, 15);
    check("to_res", a_result, 64'h1234_5678_9ABC_DEF0);
    repeat (3) tick();
    check("to_hold_st", a_st, O_TOUT);
    check("to_hold_cnt", a_count, 15);

    // Halt on zero PC: PC = 0 during RUN cycle 3
    regs  = 64'h0000_0003_0000_0033;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    tick();
    pc = 32'h0;
    tick();
    check("halt_h_st", h_st, O_DONE);
    check("halt_h_cnt", h_count, 3);
    check("halt_h_res", h_result, 64'h0000_0003_0000_0033);
    check("halt_a_st", a_st, O_ACTIVE);
    check("halt_a_cnt", a_count, 3);
    repeat (12) tick();
    check("halt_a_tout_st", a_st, O_TOUT);
    check("halt_a_tout_cnt", a_count, 15);
    check("halt_h_hold_cnt", h_count, 3);
    pc = 32'h0000_0100;

    // Stop on the same cycle the timeout would fire
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    repeat (14) tick();
    check("sim_pre_cnt", a_count, 14);
    active = 1'b0;
    tick();
    check("sim_st", a_st, O_DONE);
    check("sim_cnt", a_count, 15);

    // Reset fault: active stays low through CHECK
    start = 1'b1;
    tick();
    start = 1'b0;
    check("flt_clear_cnt", a_count, 0);
    tick();
    check("flt_check_st", a_st, O_ACTIVE);
    tick();
    check("flt_st", a_st, O_FAULT);
    check("flt_cnt", a_count, 0);
    check("flt_res", a_result, 0);

    // Controller reset during RUN cycle 4
    start = 1'b1;
    tick();
    start  = 1'b0;
    active = 1'b1;
    regs   = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    tick();
    repeat (3) tick();
    check("mid_pre_cnt", a_count, 3);
    reset = 1'b0;
    tick();
    check("mid_st", a_st, O_IDLE);
    check("mid_cnt", a_count, 0);
    check("mid_res", a_result, 0);
    check("mid_h_st", h_st, O_IDLE);
    reset = 1'b1;
    tick();
    check("mid_idle_st", a_st, O_IDLE);
    run_to_done("after_rst", 5, 32'h0000_002A);
    run_to_done("rerun", 5, 32'h0000_002A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
